// File: rtl/bus2_line_master_pkg.sv
// rtl/bus2_line_master_pkg.sv - bus2 widths, C2 command codes and master FSM states
package bus2_line_master_pkg;

    localparam int BUS2_CACHE_LINE_SIZE   = 16;
    localparam int BUS2_CACHE_OFFSET_SIZE = $clog2(BUS2_CACHE_LINE_SIZE);
    localparam int BUS2_ADDR2_BUS_SIZE    = 15;
    localparam int BUS2_DATA_BUS_SIZE     = 16;
    localparam int BUS2_CTR2_BUS_SIZE     = 2;

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_WAIT
    } state_e;

    // A one-beat line still needs a 1-bit counter to keep the declarations legal.
    function automatic int beat_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus2_line_master_if.sv
// rtl/bus2_line_master_if.sv - cache-side request/response channel of the bus2 line master
interface bus2_line_master_if
    import bus2_line_master_pkg::*;
#(
    parameter int LINE_BYTES = BUS2_CACHE_LINE_SIZE,
    parameter int ADDR_W     = BUS2_ADDR2_BUS_SIZE
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_W-1:0]       req_addr;
    logic [8*LINE_BYTES-1:0] req_line;
    logic                    resp_valid;
    logic                    resp_err;
    logic [8*LINE_BYTES-1:0] resp_line;

    modport master (
        output req_valid, req_write, req_addr, req_line,
        input  req_ready, resp_valid, resp_err, resp_line
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_line,
        output req_ready, resp_valid, resp_err, resp_line
    );

endinterface

// File: rtl/bus2_tristate.sv
// rtl/bus2_tristate.sv - output-enable plus value to inout driver for A2, D2 and C2
module bus2_tristate #(
    parameter int A_W = 15,
    parameter int D_W = 16,
    parameter int C_W = 2
) (
    input  logic           i_a2_oe,
    input  logic [A_W-1:0] i_a2,
    input  logic           i_d2_oe,
    input  logic [D_W-1:0] i_d2,
    input  logic           i_c2_oe,
    input  logic [C_W-1:0] i_c2,
    inout  wire  [A_W-1:0] io_a2,
    inout  wire  [D_W-1:0] io_d2,
    inout  wire  [C_W-1:0] io_c2
);

    assign io_a2 = i_a2_oe ? i_a2 : {A_W{1'bz}};
    assign io_d2 = i_d2_oe ? i_d2 : {D_W{1'bz}};
    assign io_c2 = i_c2_oe ? i_c2 : {C_W{1'bz}};

endmodule

// File: rtl/bus2_line_master.sv
// rtl/bus2_line_master.sv - cache-side bus2 master running whole-line read-fill and write-back bursts
module bus2_line_master
    import bus2_line_master_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = BUS2_CACHE_LINE_SIZE,
    parameter int ADDR2_BUS_SIZE  = BUS2_ADDR2_BUS_SIZE,
    parameter int DATA_BUS_SIZE   = BUS2_DATA_BUS_SIZE,
    parameter int CTR2_BUS_SIZE   = BUS2_CTR2_BUS_SIZE,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                      CLK,
    input  logic                      RESET,
    inout  wire  [ADDR2_BUS_SIZE-1:0] A2_WIRE,
    inout  wire  [DATA_BUS_SIZE-1:0]  D2_WIRE,
    inout  wire  [CTR2_BUS_SIZE-1:0]  C2_WIRE,
    bus2_line_master_if.slave         cache
);

    localparam int N      = CACHE_LINE_SIZE / 2;
    localparam int LINE_W = 8 * CACHE_LINE_SIZE;
    localparam int BEAT_W = beat_width(N);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BEAT_W-1:0]        LAST_BEAT  = BEAT_W'(N - 1);
    localparam logic [TMO_W-1:0]         TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CTR2_BUS_SIZE-1:0] K_NOP      = CTR2_BUS_SIZE'(C2_NOP);
    localparam logic [CTR2_BUS_SIZE-1:0] K_RESPONSE = CTR2_BUS_SIZE'(C2_RESPONSE);
    localparam logic [CTR2_BUS_SIZE-1:0] K_READ     = CTR2_BUS_SIZE'(C2_READ_LINE);
    localparam logic [CTR2_BUS_SIZE-1:0] K_WRITE    = CTR2_BUS_SIZE'(C2_WRITE_LINE);

    state_e                    r_state;
    logic [BEAT_W-1:0]         r_beat;
    logic [TMO_W-1:0]          r_tmo;
    logic [ADDR2_BUS_SIZE-1:0] r_addr;
    logic [LINE_W-1:0]         r_line;
    logic                      r_resp_valid;
    logic                      r_resp_err;
    logic [LINE_W-1:0]         r_resp_line;

    state_e                    w_state_next;
    logic [BEAT_W-1:0]         w_beat_next;
    logic [TMO_W-1:0]          w_tmo_next;
    logic                      w_accept;
    logic                      w_capture;
    logic                      w_done;
    logic                      w_err;
    logic                      w_fill_ok;
    logic                      w_c2_rsp;
    logic                      w_a2_oe;
    logic                      w_d2_oe;
    logic                      w_c2_oe;
    logic [CTR2_BUS_SIZE-1:0]  w_c2_val;
    logic [DATA_BUS_SIZE-1:0]  w_d2_val;
    logic [LINE_W-1:0]         w_line_cap;

    // Beat k lives at bits [16k+15:16k], so byte 2k sits on D2[7:0].
    always_comb begin
        w_line_cap = r_line;
        w_line_cap[int'(r_beat)*DATA_BUS_SIZE +: DATA_BUS_SIZE] = D2_WIRE;
    end

    assign w_d2_val = r_line[int'(r_beat)*DATA_BUS_SIZE +: DATA_BUS_SIZE];

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_tmo_next   = r_tmo;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_fill_ok    = 1'b0;
        w_a2_oe      = 1'b0;
        w_d2_oe      = 1'b0;
        w_c2_oe      = 1'b0;
        w_c2_val     = K_NOP;
        w_c2_rsp     = (C2_WIRE == K_RESPONSE);
        unique case (r_state)
            ST_IDLE: begin
                if (cache.req_valid && !r_resp_valid) begin
                    w_accept     = 1'b1;
                    w_beat_next  = '0;
                    w_state_next = cache.req_write ? ST_WR_DATA : ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                w_a2_oe      = 1'b1;
                w_c2_oe      = 1'b1;
                w_c2_val     = K_READ;
                w_tmo_next   = '0;
                w_beat_next  = '0;
                w_state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_c2_rsp) begin
                    w_capture = 1'b1;
                    if (N == 1) begin
                        w_done       = 1'b1;
                        w_fill_ok    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_beat_next  = r_beat + 1'b1;
                        w_state_next = ST_RD_DATA;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_done       = 1'b1;
                    w_err        = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            ST_RD_DATA: begin
                // A gap inside the burst aborts; the partial line stays internal.
                if (w_c2_rsp) begin
                    w_capture = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_done       = 1'b1;
                        w_fill_ok    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_beat_next = r_beat + 1'b1;
                    end
                end else begin
                    w_done       = 1'b1;
                    w_err        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                w_a2_oe  = 1'b1;
                w_d2_oe  = 1'b1;
                w_c2_oe  = 1'b1;
                w_c2_val = (r_beat == '0) ? K_WRITE : K_NOP;
                if (r_beat == LAST_BEAT) begin
                    w_beat_next  = '0;
                    w_tmo_next   = '0;
                    w_state_next = ST_WR_WAIT;
                end else begin
                    w_beat_next = r_beat + 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (w_c2_rsp) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_done       = 1'b1;
                    w_err        = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_tmo        <= '0;
            r_addr       <= '0;
            r_line       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_line  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_beat       <= w_beat_next;
            r_tmo        <= w_tmo_next;
            r_resp_valid <= w_done;
            r_resp_err   <= w_done & w_err;
            if (w_accept) begin
                r_addr <= cache.req_addr;
                r_line <= cache.req_line;
            end else if (w_capture) begin
                r_line <= w_line_cap;
            end
            if (w_fill_ok) begin
                r_resp_line <= w_line_cap;
            end
        end
    end

    // Holding req_ready low during the resp_valid cycle guarantees an idle gap between transfers.
    assign cache.req_ready  = (r_state == ST_IDLE) && !r_resp_valid;
    assign cache.resp_valid = r_resp_valid;
    assign cache.resp_err   = r_resp_err;
    assign cache.resp_line  = r_resp_line;

    bus2_tristate #(
        .A_W (ADDR2_BUS_SIZE),
        .D_W (DATA_BUS_SIZE),
        .C_W (CTR2_BUS_SIZE)
    ) u_tristate (
        .i_a2_oe (w_a2_oe),
        .i_a2    (r_addr),
        .i_d2_oe (w_d2_oe),
        .i_d2    (w_d2_val),
        .i_c2_oe (w_c2_oe),
        .i_c2    (w_c2_val),
        .io_a2   (A2_WIRE),
        .io_d2   (D2_WIRE),
        .io_c2   (C2_WIRE)
    );

endmodule
